// File: rtl/cosaim_mac_acc_if.sv
// Purpose: handshake bundle between the product source/sum sink and cosaim_mac_acc.
// Latency: none; this is wiring only.
// Backpressure: io_prod_ready throttles products; io_sum_ready holds the result until it is consumed.
//
// Ports (signals):
//   io_start, io_len                      run request and vector length
//   io_prod_valid, io_prod_ready, io_prod product stream
//   io_sum_valid, io_sum_ready, io_sum    result handshake
//   io_sat, io_busy                       status
interface cosaim_mac_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int LEN_WIDTH  = 8
);
    logic                    io_start;
    logic [LEN_WIDTH-1:0]    io_len;
    logic                    io_prod_valid;
    logic                    io_prod_ready;
    logic [2*DATA_WIDTH-1:0] io_prod;
    logic                    io_sum_valid;
    logic                    io_sum_ready;
    logic [ACC_WIDTH-1:0]    io_sum;
    logic                    io_sat;
    logic                    io_busy;

    // Environment side: issues runs, supplies products, consumes sums.
    modport master (
        output io_start, io_len, io_prod_valid, io_prod, io_sum_ready,
        input  io_prod_ready, io_sum_valid, io_sum, io_sat, io_busy
    );

    // Accumulator side.
    modport slave (
        input  io_start, io_len, io_prod_valid, io_prod, io_sum_ready,
        output io_prod_ready, io_sum_valid, io_sum, io_sat, io_busy
    );
endinterface

// File: rtl/cosaim_mac_acc.sv
// Purpose: saturating dot-product accumulator; sums io_len unsigned products per run.
// Latency: io_sum_valid rises 1 cycle after the last product handshake; one product per cycle.
// Backpressure: io_prod_ready only in ACC; result and io_sat held in OUT until io_sum_ready.
//
// Ports:
//   clock, reset : single clock, asynchronous active-high reset
//   io (slave)   : start/len request, product stream in, sum/sat/busy out
//
// ACC_WIDTH must be >= 2*DATA_WIDTH; the product is zero-extended into the accumulator.
module cosaim_mac_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int LEN_WIDTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    cosaim_mac_acc_if.slave   io
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sat_q, sat_d;

    // One extra bit catches the carry out of the accumulator.  Once acc is at
    // its maximum any further addition (even of zero) lands at or above the
    // maximum again, so the saturated value is naturally sticky.
    logic [ACC_WIDTH:0]   sum_ext;

    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, io.io_prod};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        unique case (state_q)
            IDLE: begin
                if (io.io_start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    if (io.io_len != '0) begin
                        cnt_d   = io.io_len;
                        state_d = ACC;
                    end else begin
                        // Empty vector: report a zero sum straight away.
                        cnt_d   = '0;
                        state_d = OUT;
                    end
                end
            end

            ACC: begin
                // Ready is a pure state decode, so valid alone marks a handshake.
                if (io.io_prod_valid) begin
                    if (sum_ext[ACC_WIDTH]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_WIDTH-1:0];
                    end
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = OUT;
                    end
                end
            end

            OUT: begin
                // A start presented alongside sum_ready is dropped, not queued.
                if (io.io_sum_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // All outputs are decodes of registered state, so they follow reset
    // immediately and never depend combinationally on the inputs.
    assign io.io_prod_ready = (state_q == ACC);
    assign io.io_sum_valid  = (state_q == OUT);
    assign io.io_busy       = (state_q != IDLE);
    assign io.io_sum        = acc_q;
    assign io.io_sat        = sat_q;

endmodule

// File: tb/tb_cosaim_mac_acc.sv
module tb_cosaim_mac_acc;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int LW = 8;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    cosaim_mac_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    cosaim_mac_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    int checks = 0;
    int passed = 0;

    // Saturating reference: the true running total clipped to the accumulator range.
    function automatic logic [AW-1:0] model_sum(input longint total);
        return (total > MAXV) ? AW'(MAXV) : AW'(total);
    endfunction

    // ---------------- drive-only helpers (always entered/left at a negedge) ----------------
    task automatic start_run(input int len);
        bus.io_start = 1'b1;
        bus.io_len   = LW'(len);
        @(negedge clock);
        bus.io_start = 1'b0;
        bus.io_len   = LW'($urandom);
    endtask

    // Presents one product after 'gap' idle cycles (junk data, valid low).
    // 'waited' counts cycles the product sat unaccepted; 50 means it never was.
    task automatic send_prod(input logic [2*DW-1:0] p, input int gap, input bit poke,
                             output int waited);
        repeat (gap) begin
            bus.io_prod_valid = 1'b0;
            bus.io_prod       = (2*DW)'($urandom);
            @(negedge clock);
        end
        bus.io_prod_valid = 1'b1;
        bus.io_prod       = p;
        if (poke) begin
            bus.io_start = 1'b1;
            bus.io_len   = LW'($urandom_range(1, 255));
        end
        waited = 0;
        while (bus.io_prod_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        @(negedge clock);
        bus.io_prod_valid = 1'b0;
        bus.io_start      = 1'b0;
        bus.io_prod       = (2*DW)'($urandom);
    endtask

    task automatic release_sum(input bit with_start);
        bus.io_sum_ready = 1'b1;
        bus.io_start     = with_start;
        bus.io_len       = LW'(3);
        @(negedge clock);
        bus.io_sum_ready = 1'b0;
        bus.io_start     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int w;
        #1;
        checks++; if (bus.io_prod_ready !== 1'b0) $display("FAIL reset_prod_ready: got %b expected 0", bus.io_prod_ready); else passed++;
        checks++; if (bus.io_sum_valid !== 1'b0) $display("FAIL reset_sum_valid: got %b expected 0", bus.io_sum_valid); else passed++;
        checks++; if (bus.io_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.io_busy); else passed++;
        checks++; if (bus.io_sat !== 1'b0) $display("FAIL reset_sat: got %b expected 0", bus.io_sat); else passed++;
        checks++; if (bus.io_sum !== '0) $display("FAIL reset_sum: got %0d expected 0", bus.io_sum); else passed++;
        @(negedge clock);
        // Start presented together with reset release must be taken on the first edge.
        reset        = 1'b0;
        bus.io_start = 1'b1;
        bus.io_len   = LW'(1);
        @(negedge clock);
        bus.io_start = 1'b0;
        checks++; if (bus.io_prod_ready !== 1'b1) $display("FAIL first_edge_start: got ready=%b expected 1", bus.io_prod_ready); else passed++;
        send_prod(16'd3, 0, 1'b0, w);
        checks++; if (bus.io_sum !== AW'(3)) $display("FAIL first_run_sum: got %0d expected 3", bus.io_sum); else passed++;
        release_sum(1'b0);
    endtask

    task automatic test_basic();
        int w;
        int bubbles = 0;
        start_run(4);
        send_prod(16'd100, 0, 1'b0, w); bubbles += w;
        send_prod(16'd200, 0, 1'b0, w); bubbles += w;
        send_prod(16'd300, 0, 1'b0, w); bubbles += w;
        checks++; if (bus.io_sum_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", bus.io_sum_valid); else passed++;
        send_prod(16'd400, 0, 1'b0, w); bubbles += w;
        checks++; if (bubbles !== 0) $display("FAIL basic_bubbles: got %0d expected 0", bubbles); else passed++;
        checks++; if (bus.io_sum_valid !== 1'b1) $display("FAIL basic_valid_latency: got %b expected 1", bus.io_sum_valid); else passed++;
        checks++; if (bus.io_sum !== AW'(1000)) $display("FAIL basic_sum: got %0d expected 1000", bus.io_sum); else passed++;
        checks++; if (bus.io_sat !== 1'b0) $display("FAIL basic_sat: got %b expected 0", bus.io_sat); else passed++;
        checks++; if (bus.io_prod_ready !== 1'b0) $display("FAIL basic_ready_in_out: got %b expected 0", bus.io_prod_ready); else passed++;
        release_sum(1'b0);
        checks++; if (bus.io_busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", bus.io_busy); else passed++;
    endtask

    task automatic test_gapped_backpressure();
        int w;
        int stall = 0;
        start_run(3);
        send_prod(16'd7, 2, 1'b0, w);     stall += w;
        send_prod(16'd0, 3, 1'b0, w);     stall += w;
        send_prod(16'd65535, 1, 1'b0, w); stall += w;
        checks++; if (stall !== 0) $display("FAIL gapped_stall: got %0d expected 0", stall); else passed++;
        checks++; if (bus.io_sum_valid !== 1'b1) $display("FAIL gapped_valid: got %b expected 1", bus.io_sum_valid); else passed++;
        for (int i = 0; i < 5; i++) begin
            bus.io_start = (i == 2);
            bus.io_len   = LW'(5);
            @(negedge clock);
            checks++; if (bus.io_sum !== AW'(65542)) $display("FAIL hold_sum[%0d]: got %0d expected 65542", i, bus.io_sum); else passed++;
            checks++; if (bus.io_busy !== 1'b1 || bus.io_sum_valid !== 1'b1 || bus.io_sat !== 1'b0)
                $display("FAIL hold_status[%0d]: got busy=%b valid=%b sat=%b expected 1 1 0", i, bus.io_busy, bus.io_sum_valid, bus.io_sat);
            else passed++;
        end
        bus.io_start = 1'b0;
        release_sum(1'b1);
        checks++; if (bus.io_busy !== 1'b0) $display("FAIL start_with_sum_ready: got busy=%b expected 0", bus.io_busy); else passed++;
    endtask

    task automatic test_saturation();
        int w;
        int lens[3]  = '{16, 17, 1};
        int vals[3]  = '{65535, 65535, 5};
        int sums[3]  = '{1048560, 1048575, 5};
        bit sats[3]  = '{1'b0, 1'b1, 1'b0};
        for (int r = 0; r < 3; r++) begin
            start_run(lens[r]);
            for (int k = 0; k < lens[r]; k++) send_prod((2*DW)'(vals[r]), 0, 1'b0, w);
            checks++; if (bus.io_sum !== AW'(sums[r])) $display("FAIL sat_sum[%0d]: got %0d expected %0d", r, bus.io_sum, sums[r]); else passed++;
            checks++; if (bus.io_sat !== sats[r]) $display("FAIL sat_flag[%0d]: got %b expected %b", r, bus.io_sat, sats[r]); else passed++;
            release_sum(1'b0);
        end
    endtask

    task automatic test_zero_len_ignored_start();
        int w;
        logic [15:0] a, b;
        start_run(0);
        checks++; if (bus.io_sum_valid !== 1'b1) $display("FAIL zero_len_valid: got %b expected 1", bus.io_sum_valid); else passed++;
        checks++; if (bus.io_sum !== '0) $display("FAIL zero_len_sum: got %0d expected 0", bus.io_sum); else passed++;
        release_sum(1'b0);
        a = 16'($urandom);
        b = 16'($urandom);
        start_run(2);
        send_prod(a, 0, 1'b1, w);
        send_prod(b, 1, 1'b1, w);
        checks++; if (bus.io_sum !== AW'(a) + AW'(b)) $display("FAIL ignored_start_sum: got %0d expected %0d", bus.io_sum, AW'(a) + AW'(b)); else passed++;
        release_sum(1'b0);
        checks++; if (bus.io_busy !== 1'b0) $display("FAIL ignored_start_busy: got %b expected 0", bus.io_busy); else passed++;
    endtask

    task automatic test_reset_mid_op();
        int w;
        start_run(4);
        send_prod(16'd1000, 0, 1'b0, w);
        send_prod(16'd2000, 0, 1'b0, w);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.io_busy !== 1'b0 || bus.io_prod_ready !== 1'b0 || bus.io_sum_valid !== 1'b0)
            $display("FAIL midreset_ctrl: got busy=%b ready=%b valid=%b expected 0 0 0", bus.io_busy, bus.io_prod_ready, bus.io_sum_valid);
        else passed++;
        checks++; if (bus.io_sum !== '0 || bus.io_sat !== 1'b0) $display("FAIL midreset_data: got sum=%0d sat=%b expected 0 0", bus.io_sum, bus.io_sat); else passed++;
        @(negedge clock);
        reset = 1'b0;
        start_run(1);
        send_prod(16'd9, 0, 1'b0, w);
        checks++; if (bus.io_sum !== AW'(9) || bus.io_sum_valid !== 1'b1) $display("FAIL midreset_rerun: got sum=%0d valid=%b expected 9 1", bus.io_sum, bus.io_sum_valid); else passed++;
        release_sum(1'b0);
    endtask

    task automatic test_random();
        int w, len, hold, stall;
        bit big;
        longint total;
        logic [15:0] p;
        logic [AW-1:0] exp_sum;
        for (int it = 0; it < 25; it++) begin
            big   = ($urandom_range(0, 3) == 0);
            len   = big ? $urandom_range(14, 20) : $urandom_range(0, 8);
            total = 0;
            stall = 0;
            start_run(len);
            for (int k = 0; k < len; k++) begin
                p = big ? 16'($urandom_range(60000, 65535)) : 16'($urandom);
                total += longint'(p);
                send_prod(p, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), w);
                stall += w;
            end
            exp_sum = model_sum(total);
            checks++; if (stall !== 0) $display("FAIL rand_stall[%0d]: got %0d expected 0", it, stall); else passed++;
            checks++; if (bus.io_sum_valid !== 1'b1) $display("FAIL rand_valid[%0d]: got %b expected 1", it, bus.io_sum_valid); else passed++;
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clock);
            checks++; if (bus.io_sum !== exp_sum) $display("FAIL rand_sum[%0d]: got %0d expected %0d", it, bus.io_sum, exp_sum); else passed++;
            checks++; if (bus.io_sat !== (total > MAXV)) $display("FAIL rand_sat[%0d]: got %b expected %b", it, bus.io_sat, (total > MAXV)); else passed++;
            release_sum($urandom_range(0, 1) == 1);
            checks++; if (bus.io_busy !== 1'b0) $display("FAIL rand_busy[%0d]: got %b expected 0", it, bus.io_busy); else passed++;
        end
    endtask

    initial begin
        bus.io_start      = 1'b0;
        bus.io_len        = '0;
        bus.io_prod_valid = 1'b0;
        bus.io_prod       = '0;
        bus.io_sum_ready  = 1'b0;
        test_reset();
        test_basic();
        test_gapped_backpressure();
        test_saturation();
        test_zero_len_ignored_start();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cosaim_mac_acc.md
COSAIM_MAC_ACC -- requirements
Module: cosaim_mac_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand width of the upstream multiplier; product width is 2*DATA_WIDTH.
REQ-002 Parameter ACC_WIDTH, default 20: accumulator and result width; ACC_WIDTH SHALL be >= 2*DATA_WIDTH.
REQ-003 Parameter LEN_WIDTH, default 8: width of the vector-length field.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 io_start  input  1  request to begin one dot-product accumulation.
REQ-007 io_len  input  LEN_WIDTH  number of products to accumulate; sampled only on an accepted start.
REQ-008 io_prod_valid  input  1  upstream product valid.
REQ-009 io_prod_ready  output  1  block accepts a product this cycle.
REQ-010 io_prod  input  2*DATA_WIDTH  unsigned product from the upstream multiplier's mul_result.
REQ-011 io_sum_valid  output  1  final sum available.
REQ-012 io_sum_ready  input  1  downstream consumes the sum.
REQ-013 io_sum  output  ACC_WIDTH  unsigned accumulated sum.
REQ-014 io_sat  output  1  sticky flag: saturation occurred during the current or most recent accumulation.
REQ-015 io_busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACC and OUT.
REQ-017 IDLE with io_start=1 and io_len>0: clear the accumulator and io_sat, load count=io_len, go to ACC.
REQ-018 IDLE with io_start=1 and io_len=0: clear the accumulator and io_sat, go directly to OUT.
REQ-019 io_start SHALL be ignored in ACC and OUT.
REQ-020 io_prod_ready SHALL be 1 only in ACC, as a registered-state decode with no combinational dependence on io_prod_valid.
REQ-021 On a product handshake (valid and ready both 1), acc <= acc + zero-extended io_prod, and count decrements by 1.
REQ-022 Any handshake cycle without valid SHALL leave acc and count unchanged.
REQ-023 Saturation: if the true sum exceeds 2^ACC_WIDTH-1, acc SHALL take 2^ACC_WIDTH-1 and io_sat SHALL set and remain set until the next accepted start or reset.
REQ-024 Saturated acc SHALL remain at its maximum value for all later additions.
REQ-025 Last product: the handshake taken with count=1 SHALL move the state to OUT.
REQ-026 io_sum_valid SHALL rise in the cycle immediately after the last handshake; latency from last product to valid is 1 cycle.
REQ-027 In OUT, io_sum_valid=1 and io_sum=acc; io_sum and io_sat SHALL stay stable until io_sum_ready=1.
REQ-028 OUT with io_sum_ready=1: go to IDLE. io_start in that same cycle is ignored.
REQ-029 io_sum SHALL continuously reflect acc in every state; its value is defined only while io_sum_valid=1.
REQ-030 Back-to-back products: one handshake per cycle SHALL be sustained in ACC with no bubbles.

Reset
REQ-031 While reset=1, independent of clock: state=IDLE, acc=0, count=0, io_sat=0, io_prod_ready=0, io_sum_valid=0, io_busy=0.
REQ-032 Reset asserted mid-ACC or mid-OUT SHALL abandon the operation with no partial result emitted.
REQ-033 After reset deasserts, the block SHALL accept io_start on the first clock edge.

Verification
REQ-034 Basic: start with len=4; products 100, 200, 300, 400 on consecutive cycles -> one cycle after the 4th handshake, sum_valid=1, sum=1000, sat=0.
REQ-035 Gapped input and backpressure: len=3; products 7, 0, 65535 with idle valid cycles between them; sum_ready held low 5 cycles -> sum=65542 held stable throughout, busy=1 until the ready handshake.
REQ-036 Saturation boundary (ACC_WIDTH=20): len=16 of 65535 -> sum=1048560, sat=0; len=17 of 65535 -> sum=1048575, sat=1; a following len=1 of value 5 -> sum=5, sat=0.
REQ-037 Zero length and ignored start: len=0 -> sum_valid on the next cycle with sum=0; io_start pulsed during ACC of a len=2 run -> no effect, sum equals that run's two products.
REQ-038 Reset mid-operation: reset asserted after 2 of 4 products -> all outputs at reset values immediately; a new len=1 run with product 9 -> sum=9.
